// File: rtl/bsg_manycore_link_fifo_converter_pkg.sv
// Shared manycore-link constants and width helpers for the link FIFO converter.
package bsg_manycore_link_fifo_converter_pkg;

    localparam int link_fifo_host_width_gp = 32;
    localparam int link_fifo_pkt_width_gp  = 128;
    localparam int link_fifo_rcv_els_gp    = 4;
    localparam int link_fifo_th_gp         = 2;

    // Host words per manycore packet.
    function automatic int link_words(input int pkt_width, input int host_width);
        return pkt_width / host_width;
    endfunction

    // Bits needed to hold the values 0..x inclusive (vacancy counters).
    function automatic int bsg_width(input int x);
        return $clog2(x + 1);
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int bsg_safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bsg_manycore_link_fifo_converter_chan.sv
// One channel: host-word upsizer to packets, and packet receive FIFO
// with a word-serializing downsizer back to the host.
module bsg_manycore_link_fifo_converter_chan
    import bsg_manycore_link_fifo_converter_pkg::*;
#(
    parameter int host_width_p = link_fifo_host_width_gp,
    parameter int pkt_width_p  = link_fifo_pkt_width_gp,
    parameter int rcv_els_p    = link_fifo_rcv_els_gp,
    parameter int th_p         = link_fifo_th_gp,
    localparam int vac_width_lp = bsg_width(rcv_els_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    h2m_v_i,
    input  logic [host_width_p-1:0] h2m_data_i,
    output logic                    h2m_ready_o,
    output logic                    pkt_v_o,
    output logic [pkt_width_p-1:0]  pkt_data_o,
    input  logic                    pkt_ready_i,
    input  logic                    m2h_pkt_v_i,
    input  logic [pkt_width_p-1:0]  m2h_pkt_data_i,
    output logic                    m2h_pkt_ready_o,
    output logic                    m2h_v_o,
    output logic [host_width_p-1:0] m2h_data_o,
    input  logic                    m2h_yumi_i,
    input  logic                    flush_i,
    output logic [vac_width_lp-1:0] vacancy_o,
    output logic                    rcv_th_o,
    output logic                    err_o
);

    localparam int words_lp = link_words(pkt_width_p, host_width_p);
    localparam int cnt_w_lp = bsg_width(words_lp);
    localparam int idx_w_lp = bsg_safe_clog2(words_lp);
    localparam int ptr_w_lp = bsg_safe_clog2(rcv_els_p);
    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(rcv_els_p - 1);

    logic                                    rdy_en_r;
    logic [cnt_w_lp-1:0]                     cnt_r;
    logic [words_lp-1:0][host_width_p-1:0]   up_data_r;
    logic [idx_w_lp-1:0]                     wr_slot;
    logic                                    h2m_xfer, pkt_xfer;

    logic [pkt_width_p-1:0]                  mem_r [rcv_els_p];
    logic [ptr_w_lp-1:0]                     wptr_r, rptr_r;
    logic [vac_width_lp-1:0]                 count_r;
    logic [idx_w_lp-1:0]                     idx_r;
    logic [words_lp-1:0][host_width_p-1:0]   head_w;
    logic                                    full, enq, yumi_ok, last_word, deq;
    logic                                    err_r;

    // Handshake enable: held low through reset and the first cycle after it.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) rdy_en_r <= 1'b0;
        else            rdy_en_r <= 1'b1;
    end

    // Upsizer: a full word count means a packet is presented.
    assign pkt_v_o     = (cnt_r == cnt_w_lp'(words_lp));
    assign pkt_data_o  = up_data_r;
    assign pkt_xfer    = pkt_v_o & pkt_ready_i & ~flush_i;
    assign h2m_ready_o = rdy_en_r & ~flush_i & (~pkt_v_o | pkt_ready_i);
    assign h2m_xfer    = h2m_v_i & h2m_ready_o;
    // A word arriving as the packet leaves starts the next packet in slot 0.
    assign wr_slot     = pkt_xfer ? '0 : cnt_r[idx_w_lp-1:0];

    // Upsizer word counter.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)    cnt_r <= '0;
        else if (flush_i)  cnt_r <= '0;
        else if (pkt_xfer) cnt_r <= h2m_xfer ? cnt_w_lp'(1) : '0;
        else if (h2m_xfer) cnt_r <= cnt_r + 1'b1;
    end

    // Upsizer data slots, not reset.
    always_ff @(posedge clk_i) begin
        if (h2m_xfer) up_data_r[wr_slot] <= h2m_data_i;
    end

    // Receive side: ready comes from full only, so a full FIFO refuses
    // even when the head is leaving this cycle.
    assign full            = (count_r == vac_width_lp'(rcv_els_p));
    assign m2h_pkt_ready_o = rdy_en_r & ~full & ~flush_i;
    assign enq             = m2h_pkt_v_i & m2h_pkt_ready_o;
    assign m2h_v_o         = (count_r != '0);
    assign head_w          = mem_r[rptr_r];
    assign m2h_data_o      = head_w[idx_r];
    assign last_word       = (idx_r == idx_w_lp'(words_lp - 1));
    assign yumi_ok         = m2h_yumi_i & m2h_v_o & ~flush_i;
    assign deq             = yumi_ok & last_word;
    assign vacancy_o       = vac_width_lp'(rcv_els_p) - count_r;
    assign rcv_th_o        = (vacancy_o < vac_width_lp'(th_p));
    assign err_o           = err_r;

    // FIFO pointers, occupancy and serializer word index.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            idx_r   <= '0;
        end else if (flush_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            idx_r   <= '0;
        end else begin
            if (enq)     wptr_r <= (wptr_r == last_ptr_lp) ? '0 : wptr_r + 1'b1;
            if (deq)     rptr_r <= (rptr_r == last_ptr_lp) ? '0 : rptr_r + 1'b1;
            if (yumi_ok) idx_r  <= last_word ? '0 : idx_r + 1'b1;
            case ({enq, deq})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage, not reset.
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wptr_r] <= m2h_pkt_data_i;
    end

    // Sticky error: host took a word that was not there.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)                   err_r <= 1'b0;
        else if (m2h_yumi_i & ~m2h_v_o)   err_r <= 1'b1;
    end

    // A presented packet only drops through a transfer or a flush.
    assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (pkt_v_o && !pkt_ready_i && !flush_i) |=> pkt_v_o);

endmodule

// File: rtl/bsg_manycore_link_fifo_converter.sv
// Multi-channel host/manycore link converter: independent per-channel
// upsizer, receive FIFO and downsizer.
module bsg_manycore_link_fifo_converter
    import bsg_manycore_link_fifo_converter_pkg::*;
#(
    parameter int num_chan_p   = 2,
    parameter int host_width_p = link_fifo_host_width_gp,
    parameter int pkt_width_p  = link_fifo_pkt_width_gp,
    parameter int rcv_els_p    = link_fifo_rcv_els_gp,
    parameter int th_p         = link_fifo_th_gp,
    localparam int vac_width_lp = bsg_width(rcv_els_p)
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic [num_chan_p-1:0]                    h2m_v_i,
    input  logic [num_chan_p-1:0][host_width_p-1:0]  h2m_data_i,
    output logic [num_chan_p-1:0]                    h2m_ready_o,
    output logic [num_chan_p-1:0]                    pkt_v_o,
    output logic [num_chan_p-1:0][pkt_width_p-1:0]   pkt_data_o,
    input  logic [num_chan_p-1:0]                    pkt_ready_i,
    input  logic [num_chan_p-1:0]                    m2h_pkt_v_i,
    input  logic [num_chan_p-1:0][pkt_width_p-1:0]   m2h_pkt_data_i,
    output logic [num_chan_p-1:0]                    m2h_pkt_ready_o,
    output logic [num_chan_p-1:0]                    m2h_v_o,
    output logic [num_chan_p-1:0][host_width_p-1:0]  m2h_data_o,
    input  logic [num_chan_p-1:0]                    m2h_yumi_i,
    input  logic [num_chan_p-1:0]                    flush_i,
    output logic [num_chan_p-1:0][vac_width_lp-1:0]  vacancy_o,
    output logic [num_chan_p-1:0]                    rcv_th_o,
    output logic [num_chan_p-1:0]                    err_o
);

    for (genvar c = 0; c < num_chan_p; c++) begin : g_chan
        bsg_manycore_link_fifo_converter_chan #(
            .host_width_p (host_width_p),
            .pkt_width_p  (pkt_width_p),
            .rcv_els_p    (rcv_els_p),
            .th_p         (th_p)
        ) u_chan (
            .clk_i           (clk_i),
            .reset_n_i       (reset_n_i),
            .h2m_v_i         (h2m_v_i[c]),
            .h2m_data_i      (h2m_data_i[c]),
            .h2m_ready_o     (h2m_ready_o[c]),
            .pkt_v_o         (pkt_v_o[c]),
            .pkt_data_o      (pkt_data_o[c]),
            .pkt_ready_i     (pkt_ready_i[c]),
            .m2h_pkt_v_i     (m2h_pkt_v_i[c]),
            .m2h_pkt_data_i  (m2h_pkt_data_i[c]),
            .m2h_pkt_ready_o (m2h_pkt_ready_o[c]),
            .m2h_v_o         (m2h_v_o[c]),
            .m2h_data_o      (m2h_data_o[c]),
            .m2h_yumi_i      (m2h_yumi_i[c]),
            .flush_i         (flush_i[c]),
            .vacancy_o       (vacancy_o[c]),
            .rcv_th_o        (rcv_th_o[c]),
            .err_o           (err_o[c])
        );
    end

endmodule

// File: doc/bsg_manycore_link_fifo_converter.md
BSG_MANYCORE_LINK_FIFO_CONVERTER -- requirements
Module: bsg_manycore_link_fifo_converter

Interface
REQ-001 Parameter num_chan_p, default 2: number of independent channels; legal values are 1 and above.
REQ-002 Parameter host_width_p, default 32: width of a host-side word.
REQ-003 Parameter pkt_width_p, default 128: width of a manycore-side packet; pkt_width_p/host_width_p = words_lp, an integer of 2 or more.
REQ-004 Parameter rcv_els_p, default 4: depth of each channel's receive FIFO, in packets.
REQ-005 Parameter th_p, default 2: vacancy threshold; legal range 1..rcv_els_p.
REQ-006 One clock; reset is asynchronous and active-low. Ports: clk_i (in, 1) is the clock; reset_n_i (in, 1) is the reset.
REQ-007 h2m_v_i  in  [num_chan_p]  host word valid.
REQ-008 h2m_data_i  in  [num_chan_p][host_width_p]  host word.
REQ-009 h2m_ready_o  out  [num_chan_p]  host word accepted when v&ready.
REQ-010 pkt_v_o / pkt_data_o[pkt_width_p] / pkt_ready_i  out/out/in  [num_chan_p]  assembled packet to the endpoint, valid/ready handshake.
REQ-011 m2h_pkt_v_i / m2h_pkt_data_i[pkt_width_p] / m2h_pkt_ready_o  in/in/out  [num_chan_p]  packet from the endpoint, valid/ready handshake.
REQ-012 m2h_v_o / m2h_data_o[host_width_p] / m2h_yumi_i  out/out/in  [num_chan_p]  serialized word to the host, valid/yumi handshake.
REQ-013 flush_i  in  [num_chan_p]  one-cycle synchronous per-channel discard.
REQ-014 vacancy_o  out  [num_chan_p][BSG_WIDTH(rcv_els_p)]  number of free receive FIFO entries.
REQ-015 rcv_th_o  out  [num_chan_p]  asserted when vacancy_o < th_p.
REQ-016 err_o  out  [num_chan_p]  sticky protocol-error flag.

Function
REQ-017 Channels are fully independent; every rule below applies per channel.
REQ-018 Upsizer: word k of a packet (k = 0..words_lp-1, in arrival order) is placed at pkt_data_o[k*host_width_p +: host_width_p].
REQ-019 Upsizer count cnt ranges 0..words_lp and increments on each accepted word.
REQ-020 pkt_v_o = (cnt==words_lp); it asserts the cycle after the final word is accepted and holds, with stable data, until pkt_ready_i.
REQ-021 h2m_ready_o = !flush_i & ((cnt<words_lp) | (pkt_v_o & pkt_ready_i)); a word may be accepted in the same cycle a packet leaves, giving a sustained rate of one packet per words_lp cycles.
REQ-022 Receive FIFO: m2h_pkt_ready_o = !full & !flush_i; it is independent of m2h_pkt_v_i.
REQ-023 An enqueue in cycle t makes m2h_v_o visible at t+1 when the FIFO was previously empty.
REQ-024 Downsizer: m2h_v_o = FIFO non-empty; m2h_data_o = word idx of the FIFO head, where idx starts at 0.
REQ-025 Each yumi increments idx; the yumi on word words_lp-1 dequeues the head and returns idx to 0.
REQ-026 Simultaneous enqueue into a full FIFO and final-word dequeue: not accepted, because ready was derived from full.
REQ-027 vacancy_o = rcv_els_p minus stored packets; the packet under serialization counts as stored.
REQ-028 Enqueue decrements vacancy_o and final-word dequeue increments it; both in the same cycle leave it unchanged.
REQ-029 vacancy_o never leaves the range 0..rcv_els_p.
REQ-030 flush_i in cycle t: at t+1, cnt=0, pkt_v_o=0, FIFO empty, idx=0, vacancy_o=rcv_els_p.
REQ-031 During a flush cycle no word or packet is accepted; a pkt_ready_i in that cycle completes no transfer.
REQ-032 err_o is set on m2h_yumi_i while !m2h_v_o, or on pkt_v_o falling without pkt_ready_i (impossible by design; kept as an assertion).
REQ-033 err_o stays set until reset; flush_i does not clear it.

Reset
REQ-034 While reset_n_i=0, asynchronously: cnt=0, pkt_v_o=0, h2m_ready_o=0, m2h_pkt_ready_o=0, m2h_v_o=0, idx=0, err_o=0, rcv_th_o=0, and vacancy_o=rcv_els_p.
REQ-035 The data registers are not reset.
REQ-036 h2m_ready_o and m2h_pkt_ready_o are 0 during reset and in the first cycle after deassertion; they follow REQ-021/REQ-022 from the second cycle on.
REQ-037 A reset asserted mid-packet discards all partial state and produces no output transfer.

Structure
REQ-038 words_lp and the vacancy width derivation shall live in the shared manycore-link package alongside the existing link FIFO width constants.
REQ-039 The per-channel logic shall be the sub-module bsg_manycore_link_fifo_converter_chan, instantiated num_chan_p times in a generate loop.
REQ-040 The receive FIFO shall reuse the codebase's small 1r1w FIFO, modified for asynchronous reset, or be an inline register array.

Verification (defaults unless stated)
REQ-041 Ch0: words 0x11,0x22,0x33,0x44 on consecutive cycles with pkt_ready_i=1 -> pkt_v_o=1 one cycle after the fourth word, pkt_data_o=0x00000044_00000033_00000022_00000011, gone the next cycle; ch1 outputs unchanged.
REQ-042 Ch1: five packets pushed with m2h_yumi_i=0 -> four accepted, then m2h_pkt_ready_o=0; vacancy_o steps 4,3,2,1,0; rcv_th_o asserts once vacancy_o=1.
REQ-043 Ch0: packet 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA enqueued, yumi held high -> m2h_data_o AA..,BB..,CC..,DD.. on four consecutive cycles; vacancy_o returns to 4 after DD...
REQ-044 Ch0: two words accepted, then flush_i pulse, then words 0x1..0x4 -> pkt_data_o=0x4_3_2_1 (each in its own 32-bit slot), with no stale words.
REQ-045 Ch0: reset_n_i dropped asynchronously mid-serialization (idx=2) -> all outputs at reset values within the same cycle; after release vacancy_o=4, m2h_v_o=0.
REQ-046 Ch1: m2h_yumi_i=1 with an empty FIFO -> err_o[1]=1 the next cycle and stays 1 through a subsequent flush_i; err_o[0]=0.
